wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_pkg.sv | 33 +++
 rtl/wb_arbiter_if.sv | 42 ++++
 rtl/wb_fifo.sv | 57 +++++
 rtl/wb_arbiter.sv | 159 +++++++++++++++
 tb/tb_wb_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the write-back arbiter slice.
// WB_BYTE_LOAD_EN adds byte/lane fields to the load-queue entry.
package wb_arbiter_pkg;

  localparam int unsigned REG_AW = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
`ifdef WB_BYTE_LOAD_EN
    logic              is_byte;
    logic              hi;
`endif
  } ldq_entry_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } hb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_HB,
    SRC_ALU
  } wb_src_e;

  function automatic logic [DATA_W-1:0] sext_byte(input logic [7:0] b);
    return {{(DATA_W-8){b[7]}}, b};
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between EX/MEM stages (master) and the write-back arbiter (slave).
// WB_BYTE_LOAD_EN adds the ld_byte/ld_hi signals.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic              flush;
  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_issue;
  logic [REG_AW-1:0] ld_rd;
`ifdef WB_BYTE_LOAD_EN
  logic              ld_byte;
  logic              ld_hi;
`endif
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [REG_AW-1:0] WB_addr;
  logic [DATA_W-1:0] WB_data;
  logic              RegWe;
  logic [NREG-1:0]   pending_mask;
  logic              stall;

  modport master (
    output flush, alu_valid, alu_rd, alu_data, ld_issue, ld_rd,
`ifdef WB_BYTE_LOAD_EN
    output ld_byte, ld_hi,
`endif
    output mem_rvalid, mem_rdata,
    input  WB_addr, WB_data, RegWe, pending_mask, stall
  );

  modport slave (
    input  flush, alu_valid, alu_rd, alu_data, ld_issue, ld_rd,
`ifdef WB_BYTE_LOAD_EN
    input  ld_byte, ld_hi,
`endif
    input  mem_rvalid, mem_rdata,
    output WB_addr, WB_data, RegWe, pending_mask, stall
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with count, full/empty and a synchronous clear.
// Depth must be a power of two; a push while full is accepted only alongside a pop.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: load responses > buffered ALU results > live ALU.
// Build option WB_BYTE_LOAD_EN enables sign-extended byte loads.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned LDQ_DEPTH = 2,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);

  localparam int unsigned LCW   = $clog2(LDQ_DEPTH) + 1;
  localparam int unsigned HCW   = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned LDQ_W = $bits(ldq_entry_t);
  localparam int unsigned HB_W  = $bits(hb_entry_t);

  ldq_entry_t        ldq_din;
  ldq_entry_t        ldq_head;
  logic [LCW-1:0]    ldq_count;
  logic              ldq_full;
  logic              ldq_empty;
  logic              ldq_push;
  logic              ldq_pop;

  hb_entry_t         hb_din;
  hb_entry_t         hb_head;
  logic [HCW-1:0]    hb_count;
  logic              hb_full;
  logic              hb_empty;
  logic              hb_push;
  logic              hb_pop;

  logic [LCW-1:0]    drop_cnt;
  logic [LCW-1:0]    rd_cnt      [NREG];
  logic [LCW-1:0]    rd_cnt_next [NREG];

  logic              rsp_hit;
  logic              drop_hit;
  logic              alu_live;
  wb_src_e           src;
  logic [DATA_W-1:0] ld_wdata;

  wb_fifo #(.DEPTH(LDQ_DEPTH), .W(LDQ_W)) u_ldq (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush),
    .push  (ldq_push),
    .din   (ldq_din),
    .pop   (ldq_pop),
    .dout  (ldq_head),
    .count (ldq_count),
    .full  (ldq_full),
    .empty (ldq_empty)
  );

  wb_fifo #(.DEPTH(BUF_DEPTH), .W(HB_W)) u_hb (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush),
    .push  (hb_push),
    .din   (hb_din),
    .pop   (hb_pop),
    .dout  (hb_head),
    .count (hb_count),
    .full  (hb_full),
    .empty (hb_empty)
  );

  assign bus.stall = (hb_count >= HCW'(BUF_DEPTH - 1)) || ldq_full;

  always_comb begin
    ldq_din    = '0;
    ldq_din.rd = bus.ld_rd;
`ifdef WB_BYTE_LOAD_EN
    ldq_din.is_byte = bus.ld_byte;
    ldq_din.hi      = bus.ld_hi;
`endif
    hb_din.rd   = bus.alu_rd;
    hb_din.data = bus.alu_data;
  end

  always_comb begin
    ld_wdata = bus.mem_rdata;
`ifdef WB_BYTE_LOAD_EN
    if (ldq_head.is_byte)
      ld_wdata = sext_byte(ldq_head.hi ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0]);
`endif
  end

  // A flush cycle selects nothing: the live ALU result and any response belong to squashed work.
  always_comb begin
    rsp_hit  = bus.mem_rvalid && (drop_cnt == '0) && !ldq_empty;
    drop_hit = bus.mem_rvalid && (drop_cnt != '0);
    alu_live = bus.alu_valid && (bus.alu_rd != '0);
    src      = SRC_NONE;
    if (!bus.flush) begin
      if (rsp_hit)        src = SRC_LOAD;
      else if (!hb_empty) src = SRC_HB;
      else if (alu_live)  src = SRC_ALU;
    end
    ldq_push = bus.ld_issue && !bus.flush && !ldq_full;
    ldq_pop  = rsp_hit;
    hb_pop   = (src == SRC_HB);
    hb_push  = alu_live && !bus.flush && (src != SRC_ALU) && (!hb_full || hb_pop);
  end

  // Per-register outstanding counts keep a mask bit set while duplicate rd loads remain queued.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      rd_cnt_next[r] = rd_cnt[r];
      if (ldq_push && (ldq_din.rd == REG_AW'(r)))  rd_cnt_next[r] = rd_cnt_next[r] + LCW'(1);
      if (ldq_pop  && (ldq_head.rd == REG_AW'(r))) rd_cnt_next[r] = rd_cnt_next[r] - LCW'(1);
      if (bus.flush) rd_cnt_next[r] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) rd_cnt[r] <= '0;
      bus.pending_mask <= '0;
      drop_cnt         <= '0;
      bus.WB_addr      <= '0;
      bus.WB_data      <= '0;
      bus.RegWe        <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        rd_cnt[r]           <= rd_cnt_next[r];
        bus.pending_mask[r] <= (rd_cnt_next[r] != '0);
      end

      // A response arriving in the flush cycle answers one of the flushed loads.
      if (bus.flush)     drop_cnt <= ldq_count - LCW'(rsp_hit);
      else if (drop_hit) drop_cnt <= drop_cnt - LCW'(1);

      bus.RegWe <= 1'b0;
      case (src)
        SRC_LOAD: begin
          bus.WB_addr <= ldq_head.rd;
          bus.WB_data <= ld_wdata;
          bus.RegWe   <= (ldq_head.rd != '0);
        end
        SRC_HB: begin
          bus.WB_addr <= hb_head.rd;
          bus.WB_data <= hb_head.data;
          bus.RegWe   <= 1'b1;
        end
        SRC_ALU: begin
          bus.WB_addr <= bus.alu_rd;
          bus.WB_data <= bus.alu_data;
          bus.RegWe   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter; each row is one cycle of stimulus
// and the outputs expected just after that clock edge.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk;
  logic rst_n;

  wb_arbiter_if bus ();

  wb_arbiter #(.LDQ_DEPTH(2), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        alu_valid;
    logic [2:0]  alu_rd;
    logic [15:0] alu_data;
    logic        ld_issue;
    logic [2:0]  ld_rd;
    logic        ld_byte;
    logic        ld_hi;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        flush;
    logic        exp_we;
    logic [2:0]  exp_addr;
    logic [15:0] exp_data;
    logic [7:0]  exp_mask;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic av, input logic [2:0] ard, input logic [15:0] ad,
                     input logic li, input logic [2:0] lrd, input logic lb, input logic lh,
                     input logic rv, input logic [15:0] rdat, input logic fl,
                     input logic we, input logic [2:0] ea, input logic [15:0] ed,
                     input logic [7:0] em, input logic es);
    vec_t v;
    v.alu_valid = av;  v.alu_rd = ard; v.alu_data = ad;
    v.ld_issue  = li;  v.ld_rd  = lrd; v.ld_byte  = lb; v.ld_hi = lh;
    v.mem_rvalid = rv; v.mem_rdata = rdat; v.flush = fl;
    v.exp_we = we; v.exp_addr = ea; v.exp_data = ed; v.exp_mask = em; v.exp_stall = es;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.flush = 1'b0; bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_issue = 1'b0; bus.ld_rd = '0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
`ifdef WB_BYTE_LOAD_EN
    bus.ld_byte = 1'b0; bus.ld_hi = 1'b0;
`endif
  endtask

  task automatic apply(input vec_t v);
    bus.alu_valid = v.alu_valid; bus.alu_rd = v.alu_rd; bus.alu_data = v.alu_data;
    bus.ld_issue = v.ld_issue; bus.ld_rd = v.ld_rd;
    bus.mem_rvalid = v.mem_rvalid; bus.mem_rdata = v.mem_rdata; bus.flush = v.flush;
`ifdef WB_BYTE_LOAD_EN
    bus.ld_byte = v.ld_byte; bus.ld_hi = v.ld_hi;
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    32'(bus.RegWe),        32'h0);
    chk({tag, "_addr"},  32'(bus.WB_addr),      32'h0);
    chk({tag, "_data"},  32'(bus.WB_data),      32'h0);
    chk({tag, "_mask"},  32'(bus.pending_mask), 32'h0);
    chk({tag, "_stall"}, 32'(bus.stall),        32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   alu v/rd/data     ld iss/rd/byte/hi   rvalid/rdata   flush | we addr data    mask   stall
    add(1, 3, 16'h1234,    0, 0, 0, 0,  0, 16'h0000, 0,   1, 3, 16'h1234, 8'h00, 0); // ALU only
    add(0, 0, 16'h0000,    0, 0, 0, 0,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h00, 0);
    add(1, 0, 16'h5555,    0, 0, 0, 0,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h00, 0); // ALU to r0
    add(0, 0, 16'h0000,    1, 2, 0, 0,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h04, 0);
    add(1, 5, 16'h0007,    0, 0, 0, 0,  1, 16'hBEEF, 0,   1, 2, 16'hBEEF, 8'h00, 1); // collision
    add(0, 0, 16'h0000,    0, 0, 0, 0,  0, 16'h0000, 0,   1, 5, 16'h0007, 8'h00, 0);
    add(0, 0, 16'h0000,    1, 1, 0, 0,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h02, 0); // backpressure
    add(0, 0, 16'h0000,    1, 4, 0, 0,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h12, 1);
    add(1, 6, 16'h0A0A,    0, 0, 0, 0,  1, 16'h1111, 0,   1, 1, 16'h1111, 8'h10, 1);
    add(1, 7, 16'h0B0B,    0, 0, 0, 0,  1, 16'h2222, 0,   1, 4, 16'h2222, 8'h00, 1);
    add(0, 0, 16'h0000,    0, 0, 0, 0,  0, 16'h0000, 0,   1, 6, 16'h0A0A, 8'h00, 1);
    add(0, 0, 16'h0000,    0, 0, 0, 0,  0, 16'h0000, 0,   1, 7, 16'h0B0B, 8'h00, 0);
    add(1, 3, 16'h00FF,    0, 0, 0, 0,  0, 16'h0000, 0,   1, 3, 16'h00FF, 8'h00, 0); // back-to-back
    add(1, 4, 16'h0100,    0, 0, 0, 0,  0, 16'h0000, 0,   1, 4, 16'h0100, 8'h00, 0);
    add(0, 0, 16'h0000,    1, 1, 0, 0,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h02, 0); // same-rd order
    add(1, 5, 16'hAAAA,    0, 0, 0, 0,  1, 16'h3333, 0,   1, 1, 16'h3333, 8'h00, 1);
    add(1, 5, 16'hBBBB,    0, 0, 0, 0,  0, 16'h0000, 0,   1, 5, 16'hAAAA, 8'h00, 1);
    add(0, 0, 16'h0000,    0, 0, 0, 0,  0, 16'h0000, 0,   1, 5, 16'hBBBB, 8'h00, 0);
    add(0, 0, 16'h0000,    1, 2, 0, 0,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h04, 0); // flush
    add(0, 0, 16'h0000,    1, 3, 0, 0,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h0C, 1);
    add(0, 0, 16'h0000,    1, 6, 0, 0,  0, 16'h0000, 1,   0, 0, 16'h0000, 8'h00, 0);
    add(0, 0, 16'h0000,    0, 0, 0, 0,  1, 16'hDEAD, 0,   0, 0, 16'h0000, 8'h00, 0);
    add(0, 0, 16'h0000,    0, 0, 0, 0,  1, 16'hBEEF, 0,   0, 0, 16'h0000, 8'h00, 0);
    add(0, 0, 16'h0000,    0, 0, 0, 0,  1, 16'h9999, 0,   0, 0, 16'h0000, 8'h00, 0); // stray rvalid
    add(0, 0, 16'h0000,    1, 0, 0, 0,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h01, 0); // load to r0
    add(0, 0, 16'h0000,    0, 0, 0, 0,  1, 16'h7777, 0,   0, 0, 16'h0000, 8'h00, 0);
    add(1, 2, 16'h4242,    0, 0, 0, 0,  0, 16'h0000, 0,   1, 2, 16'h4242, 8'h00, 0);
    add(0, 0, 16'h0000,    1, 1, 0, 0,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h02, 0); // issue when full
    add(0, 0, 16'h0000,    1, 2, 0, 0,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h06, 1);
    add(0, 0, 16'h0000,    1, 3, 0, 0,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h06, 1);
    add(0, 0, 16'h0000,    0, 0, 0, 0,  1, 16'h0101, 0,   1, 1, 16'h0101, 8'h04, 0);
    add(0, 0, 16'h0000,    0, 0, 0, 0,  1, 16'h0202, 0,   1, 2, 16'h0202, 8'h00, 0);
    add(0, 0, 16'h0000,    0, 0, 0, 0,  1, 16'h0303, 0,   0, 0, 16'h0000, 8'h00, 0);
`ifdef WB_BYTE_LOAD_EN
    add(0, 0, 16'h0000,    1, 1, 1, 1,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h02, 0); // byte loads
    add(0, 0, 16'h0000,    0, 0, 0, 0,  1, 16'h80FF, 0,   1, 1, 16'hFF80, 8'h00, 0);
    add(0, 0, 16'h0000,    1, 2, 1, 0,  0, 16'h0000, 0,   0, 0, 16'h0000, 8'h04, 0);
    add(0, 0, 16'h0000,    0, 0, 0, 0,  1, 16'h80FF, 0,   1, 2, 16'hFFFF, 8'h00, 0);
`endif

    drive_idle();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i),    32'(bus.RegWe),        32'(vecs[i].exp_we));
      chk($sformatf("v%0d_mask", i),  32'(bus.pending_mask), 32'(vecs[i].exp_mask));
      chk($sformatf("v%0d_stall", i), 32'(bus.stall),        32'(vecs[i].exp_stall));
      if (vecs[i].exp_we) begin
        chk($sformatf("v%0d_addr", i), 32'(bus.WB_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("v%0d_data", i), 32'(bus.WB_data), 32'(vecs[i].exp_data));
      end
    end

    // Asynchronous reset in the middle of traffic, between clock edges.
    drive_idle();
    bus.ld_issue = 1'b1; bus.ld_rd = 3'd2;
    @(posedge clk); #1;
    bus.ld_rd = 3'd3;
    @(posedge clk); #1;
    bus.ld_issue = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hC0DE;
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd6; bus.alu_data = 16'h6666;
    @(posedge clk); #1;
    chk("pre_rst_we",    32'(bus.RegWe),        32'h1);
    chk("pre_rst_data",  32'(bus.WB_data),      32'hC0DE);
    chk("pre_rst_mask",  32'(bus.pending_mask), 32'h08);
    chk("pre_rst_stall", 32'(bus.stall),        32'h1);
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #2 rst_n = 1'b1;

    // Late response after reset: nothing outstanding, so nothing is written.
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hFACE;
    @(posedge clk); #1;
    drive_idle();
    chk("post_rst_rsp_we", 32'(bus.RegWe), 32'h0);
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd7; bus.alu_data = 16'h7A7A;
    @(posedge clk); #1;
    drive_idle();
    chk("post_rst_alu_we",   32'(bus.RegWe),   32'h1);
    chk("post_rst_alu_addr", 32'(bus.WB_addr), 32'h7);
    chk("post_rst_alu_data", 32'(bus.WB_data), 32'h7A7A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
